// File: rtl/parking_fee_calc.sv
// Parking fee calculator: stamps the timer on slot entry and turns the elapsed time into a fee on exit.
// Optional grace period (free short stays) is enabled by defining PARKING_GRACE_EN.
module parking_fee_calc #(
  parameter int SLOTS    = 8,
  parameter int SLOT_W   = 3,
  parameter int TIME_MOD = 1000,
  parameter int BLOCK    = 100,
  parameter int RATE     = 10,
  parameter int GRACE    = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        timer_count,
  input  logic              entry_valid,
  input  logic [SLOT_W-1:0] entry_slot,
  input  logic              exit_valid,
  input  logic [SLOT_W-1:0] exit_slot,
  output logic              busy,
  output logic [SLOTS-1:0]  occupied,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [SLOT_W-1:0] result_slot,
  output logic [9:0]        elapsed,
  output logic [15:0]       fee,
  output logic              err_occupied,
  output logic              err_empty
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [9:0]  BLOCK_T = 10'(BLOCK);
  localparam logic [15:0] RATE_T  = 16'(RATE);
  localparam logic [9:0]  GRACE_T = 10'(GRACE);
`ifdef PARKING_GRACE_EN
  localparam bit GRACE_ON = 1'b1;
`else
  localparam bit GRACE_ON = 1'b0;
`endif

  state_t     state;
  logic [9:0] stamp [SLOTS];
  logic [9:0] remainder;
  logic [9:0] exit_elapsed;
  logic       same_slot;
  logic       exit_hit;
  logic       entry_ok;

  // Timer distance from the stamp, folding the wrap at TIME_MOD back into range.
  function automatic logic [9:0] wrap_elapsed(input logic [9:0] now, input logic [9:0] start);
    logic [10:0] n;
    logic [10:0] s;
    n = {1'b0, now};
    s = {1'b0, start};
    if (n >= s) return 10'(n - s);
    else        return 10'(n + 11'(TIME_MOD) - s);
  endfunction

  assign exit_elapsed = wrap_elapsed(timer_count, stamp[exit_slot]);
  assign same_slot    = entry_valid && exit_valid && (entry_slot == exit_slot);
  assign exit_hit     = exit_valid && !busy && occupied[exit_slot];
  assign entry_ok     = entry_valid && !same_slot && !occupied[entry_slot];

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      occupied     <= '0;
      result_valid <= 1'b0;
      result_slot  <= '0;
      elapsed      <= '0;
      fee          <= '0;
      remainder    <= '0;
      err_occupied <= 1'b0;
      err_empty    <= 1'b0;
      for (int i = 0; i < SLOTS; i++) stamp[i] <= '0;
    end else begin
      // A same-slot entry is refused even when the paired exit is not taken.
      err_occupied <= entry_valid && (same_slot || occupied[entry_slot]);
      err_empty    <= exit_valid && !busy && !occupied[exit_slot];

      if (entry_ok) begin
        stamp[entry_slot]    <= timer_count;
        occupied[entry_slot] <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (exit_hit) begin
            occupied[exit_slot] <= 1'b0;
            elapsed             <= exit_elapsed;
            result_slot         <= exit_slot;
            remainder           <= exit_elapsed;
            fee                 <= '0;
            busy                <= 1'b1;
            if (GRACE_ON && (exit_elapsed < GRACE_T)) begin
              state        <= DONE;
              result_valid <= 1'b1;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          // One whole block per cycle; the last step rounds up and enforces the minimum charge.
          if (remainder >= BLOCK_T) begin
            remainder <= remainder - BLOCK_T;
            fee       <= fee + RATE_T;
          end else begin
            if ((remainder != '0) || (fee == '0)) fee <= fee + RATE_T;
            state        <= DONE;
            result_valid <= 1'b1;
          end
        end
        DONE: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parking_fee_calc.sv
// Directed and randomized bench for parking_fee_calc against an arithmetic reference model.
module tb_parking_fee_calc;
  localparam int SLOTS = 8, SLOT_W = 3, TIME_MOD = 1000, BLOCK = 100, RATE = 10, GRACE = 5;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [9:0]        timer_count = '0;
  logic              entry_valid = 1'b0;
  logic [SLOT_W-1:0] entry_slot = '0;
  logic              exit_valid = 1'b0;
  logic [SLOT_W-1:0] exit_slot = '0;
  logic              busy;
  logic [SLOTS-1:0]  occupied;
  logic              result_valid;
  logic              result_ready = 1'b0;
  logic [SLOT_W-1:0] result_slot;
  logic [9:0]        elapsed;
  logic [15:0]       fee;
  logic              err_occupied;
  logic              err_empty;

  int checks = 0;
  int failures = 0;
  int m_stamp [SLOTS];
  bit m_occ [SLOTS];

  parking_fee_calc #(.SLOTS(SLOTS), .SLOT_W(SLOT_W), .TIME_MOD(TIME_MOD),
                     .BLOCK(BLOCK), .RATE(RATE), .GRACE(GRACE)) dut (
    .clk(clk), .reset(reset), .timer_count(timer_count),
    .entry_valid(entry_valid), .entry_slot(entry_slot),
    .exit_valid(exit_valid), .exit_slot(exit_slot),
    .busy(busy), .occupied(occupied),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_slot(result_slot), .elapsed(elapsed), .fee(fee),
    .err_occupied(err_occupied), .err_empty(err_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int m_elapsed(input int now, input int start);
    return (now - start + TIME_MOD) % TIME_MOD;
  endfunction

  function automatic bit m_grace(input int e);
`ifdef PARKING_GRACE_EN
    return e < GRACE;
`else
    return (e < 0);
`endif
  endfunction

  function automatic int m_fee(input int e);
    if (m_grace(e)) return 0;
    if (e == 0) return RATE;
    return ((e + BLOCK - 1) / BLOCK) * RATE;
  endfunction

  function automatic int m_lat(input int e);
    if (m_grace(e)) return 0;
    return e / BLOCK + 1;
  endfunction

  function automatic logic [31:0] m_occ_vec();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < SLOTS; i++) v[i] = m_occ[i];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_entry(input int slot, input int t);
    bit exp_err;
    exp_err = m_occ[slot];
    entry_valid = 1'b1;
    entry_slot  = SLOT_W'(slot);
    timer_count = 10'(t);
    tick();
    entry_valid = 1'b0;
    chk("entry_err_occupied", 32'(err_occupied), 32'(exp_err));
    if (!exp_err) begin
      m_stamp[slot] = t;
      m_occ[slot]   = 1'b1;
    end
    chk("entry_occupied", 32'(occupied), m_occ_vec());
  endtask

  task automatic wait_result(input int slot, input int lat, input int el, input int f);
    int n;
    n = 0;
    while (!result_valid && n < 30) begin
      tick();
      n++;
    end
    chk("result_valid_rise", 32'(result_valid), 32'd1);
    chk("result_latency", 32'(n), 32'(lat));
    chk("result_elapsed", 32'(elapsed), 32'(el));
    chk("result_fee", 32'(fee), 32'(f));
    chk("result_slot", 32'(result_slot), 32'(slot));
    chk("busy_in_done", 32'(busy), 32'd1);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    chk("result_valid_drop", 32'(result_valid), 32'd0);
    chk("busy_after_handshake", 32'(busy), 32'd0);
  endtask

  task automatic do_exit(input int slot, input int t);
    int e;
    exit_valid  = 1'b1;
    exit_slot   = SLOT_W'(slot);
    timer_count = 10'(t);
    tick();
    exit_valid = 1'b0;
    if (m_occ[slot]) begin
      e = m_elapsed(t, m_stamp[slot]);
      m_occ[slot] = 1'b0;
      chk("exit_busy", 32'(busy), 32'd1);
      chk("exit_occupied", 32'(occupied), m_occ_vec());
      wait_result(slot, m_lat(e), e, m_fee(e));
    end else begin
      chk("err_empty_pulse", 32'(err_empty), 32'd1);
      chk("err_empty_busy", 32'(busy), 32'd0);
      tick();
      chk("err_empty_clear", 32'(err_empty), 32'd0);
      chk("err_empty_busy2", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int n;
    bit seen;
    for (int i = 0; i < SLOTS; i++) begin m_stamp[i] = 0; m_occ[i] = 1'b0; end

    // Reset state
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_occupied", 32'(occupied), 32'd0);
    chk("rst_result_valid", 32'(result_valid), 32'd0);
    chk("rst_fee", 32'(fee), 32'd0);
    chk("rst_elapsed", 32'(elapsed), 32'd0);
    chk("rst_result_slot", 32'(result_slot), 32'd0);
    chk("rst_errs", 32'({err_occupied, err_empty}), 32'd0);

    // Basic, wrap-around, worst case, zero stay, exact blocks
    do_entry(2, 100);  do_exit(2, 350);
    do_entry(0, 950);  do_exit(0, 30);
    do_entry(0, 0);    do_exit(0, 999);
    do_entry(4, 500);  do_exit(4, 500);
    do_entry(4, 100);  do_exit(4, 300);

    // Error pulses
    do_exit(5, 0);
    do_entry(2, 10);
    do_entry(2, 20);
    tick();
    chk("err_occupied_clear", 32'(err_occupied), 32'd0);
    do_exit(2, 110);

    // Same-cycle entry and exit on one slot
    do_entry(2, 0);
    entry_valid = 1'b1; entry_slot = 3'd2;
    exit_valid  = 1'b1; exit_slot  = 3'd2;
    timer_count = 10'd50;
    tick();
    entry_valid = 1'b0; exit_valid = 1'b0;
    m_occ[2] = 1'b0;
    chk("same_err_occupied", 32'(err_occupied), 32'd1);
    chk("same_busy", 32'(busy), 32'd1);
    chk("same_occupied", 32'(occupied), m_occ_vec());
    wait_result(2, 1, 50, 10);

    // Backpressure with held exit and concurrent entry
    do_entry(1, 0);
    do_entry(7, 0);
    exit_valid = 1'b1; exit_slot = 3'd7; timer_count = 10'd120;
    tick();
    exit_valid = 1'b0;
    m_occ[7] = 1'b0;
    n = 0;
    while (!result_valid && n < 30) begin tick(); n++; end
    chk("bp_valid", 32'(result_valid), 32'd1);
    exit_valid = 1'b1; exit_slot = 3'd1; timer_count = 10'd400;
    entry_valid = 1'b1; entry_slot = 3'd3;
    tick();
    entry_valid = 1'b0;
    m_stamp[3] = 400; m_occ[3] = 1'b1;
    chk("bp_entry_occupied", 32'(occupied), m_occ_vec());
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", 32'(result_valid), 32'd1);
      chk("bp_hold_fee", 32'(fee), 32'd20);
      chk("bp_hold_elapsed", 32'(elapsed), 32'd120);
      chk("bp_hold_slot", 32'(result_slot), 32'd7);
      chk("bp_hold_occupied", 32'(occupied), m_occ_vec());
      if (i < 4) tick();
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    chk("bp_handshake_valid", 32'(result_valid), 32'd0);
    chk("bp_not_yet_accepted", 32'(occupied), m_occ_vec());
    tick();
    exit_valid = 1'b0;
    m_occ[1] = 1'b0;
    chk("bp_accept_busy", 32'(busy), 32'd1);
    chk("bp_accept_occupied", 32'(occupied), m_occ_vec());
    wait_result(1, m_lat(400), 400, m_fee(400));

    // Reset in the middle of CALC
    do_entry(0, 0);
    exit_valid = 1'b1; exit_slot = 3'd0; timer_count = 10'd999;
    tick();
    exit_valid = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < SLOTS; i++) m_occ[i] = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(result_valid), 32'd0);
    chk("midrst_occupied", 32'(occupied), 32'd0);
    chk("midrst_fee", 32'(fee), 32'd0);
    seen = 1'b0;
    repeat (15) begin tick(); if (result_valid) seen = 1'b1; end
    chk("midrst_no_result", 32'(seen), 32'd0);

    // Randomized traffic against the model
    for (int k = 0; k < 60; k++) begin
      int s, t, r;
      s = $urandom_range(0, SLOTS - 1);
      t = $urandom_range(0, TIME_MOD - 1);
      r = $urandom_range(0, 3);
      if (m_occ[s] && r != 0) do_exit(s, t);
      else if (!m_occ[s] && r == 0) do_exit(s, t);
      else do_entry(s, t);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parking_fee_calc.md
Name: parking_fee_calc

Overview:
- Consumer of the free-running 0..999 parking timer count.
- Stamps the timer value when a car enters a slot. On exit, computes elapsed time modulo the timer period and converts it into a fee with a multi-cycle block-counting FSM.
- Sits between the gate/slot controller (entry/exit events) and the payment/display logic (result handshake).

Parameters:
- SLOTS, 8, number of parking slots.
- SLOT_W, 3, slot index width; must satisfy 2**SLOT_W >= SLOTS.
- TIME_MOD, 1000, timer period; the timer counts 0..TIME_MOD-1.
- BLOCK, 100, timer ticks per charged block.
- RATE, 10, fee units per block.
- GRACE, 5, grace ticks; used only with the optional feature.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- timer_count  in  10  current timer value, 0..999
- entry_valid  in  1  entry event, single-cycle
- entry_slot  in  SLOT_W  slot being entered
- exit_valid  in  1  exit request; held by the source until accepted
- exit_slot  in  SLOT_W  slot being exited
- busy  out  1  high while in CALC or DONE; an exit is accepted only when busy=0
- occupied  out  SLOTS  per-slot occupancy flags
- result_valid  out  1  result available
- result_ready  in  1  consumer accepts the result
- result_slot  out  SLOT_W  slot of the result
- elapsed  out  10  elapsed ticks, 0..999
- fee  out  16  computed fee
- err_occupied  out  1  one-cycle pulse: entry to an occupied slot rejected
- err_empty  out  1  one-cycle pulse: exit from an empty slot rejected

Behaviour:
- Reset (synchronous, active-high):
  - State returns to IDLE.
  - All outputs go to 0: occupied, busy, result_valid, result_slot, elapsed, fee, err_*.
  - The stamp table is cleared.
  - Reset mid-CALC or mid-DONE aborts the operation; no result is produced.
- Entry (accepted in any state):
  - entry_valid with slot free: stamp[slot] <= timer_count and occupied[slot] <= 1 at the same edge.
  - Slot already occupied: no change; err_occupied pulses for the next cycle.
- Exit (accepted only when exit_valid=1 and busy=0):
  - Slot empty: err_empty pulses; state stays IDLE.
  - Slot occupied, at the acceptance edge:
    - occupied[slot] <= 0.
    - elapsed <= timer_count - stamp if timer_count >= stamp, else timer_count + TIME_MOD - stamp.
    - result_slot <= slot; fee <= 0; remainder <= elapsed value; state -> CALC.
  - exit_valid while busy=1 is ignored; the source keeps holding it.
- Same-cycle entry and exit on the same slot:
  - The exit is evaluated first.
  - The entry is always rejected with err_occupied, whether or not the exit is accepted.
  - Entry and exit on different slots are both processed.
- FSM states IDLE, CALC, DONE:
  - CALC, each cycle:
    - If remainder >= BLOCK: remainder -= BLOCK, fee += RATE, stay in CALC.
    - Else if remainder != 0 or fee == 0: fee += RATE, go to DONE. This rounds up a partial block and applies a minimum charge of one block.
    - Else: go to DONE.
  - CALC duration is floor(elapsed/BLOCK)+1 cycles; worst case is 10 cycles for elapsed=999.
  - DONE: result_valid=1. result_slot, elapsed and fee are held stable until the cycle where result_valid and result_ready are both 1, then result_valid <= 0 and the state goes to IDLE.
  - result_ready outside DONE is ignored.
- Arithmetic:
  - Elapsed uses 11-bit intermediates.
  - fee is 16 bits and cannot overflow with the default parameters.

Optional Feature:
- Macro: PARKING_GRACE_EN.
- Defined: at exit acceptance, if elapsed < GRACE, fee <= 0 and the state goes directly to DONE. result_valid then rises the cycle after acceptance, and no minimum charge is applied. Otherwise behaviour is as without the macro.
- Undefined: there is no grace check, and every stay is charged at least RATE.

Test Plan:
- Basic exit:
  - Stimulus: entry slot 2 at timer 100; exit slot 2 at timer 350.
  - Response: elapsed=250, fee=30, result_slot=2, result_valid 3 cycles after acceptance, occupied[2]=0.
- Wrap-around:
  - Stimulus: entry slot 0 at timer 950; exit at timer 30.
  - Response: elapsed=80, fee=10.
  - Also: entry at 0, exit at 999 gives elapsed=999, fee=100 after 10 CALC cycles.
- Zero and exact-block stays:
  - Stimulus: entry and exit at timer 500.
  - Response: fee=10 without the macro; fee=0 with PARKING_GRACE_EN, result_valid one cycle after acceptance.
  - Also: elapsed=200 gives fee=20.
- Error pulses:
  - Stimulus: exit on empty slot 5.
  - Response: err_empty for one cycle, busy stays 0.
  - Stimulus: entry on slot 2 twice.
  - Response: second entry gives err_occupied for one cycle and the stamp is unchanged.
  - Stimulus: same-cycle entry and exit on slot 2.
  - Response: exit is processed and err_occupied pulses.
- Backpressure and concurrent entry:
  - Stimulus: hold result_ready=0 for 5 cycles in DONE while exit_valid is held on slot 1 and entry slot 3 arrives.
  - Response: fee, elapsed and result_slot are stable; the slot 1 exit is not accepted; occupied[3]=1 is set; after the handshake, the slot 1 exit is accepted the next IDLE cycle.
- Reset mid-CALC:
  - Stimulus: assert reset during CALC for elapsed=999.
  - Response: next cycle busy=0, result_valid=0, occupied=0, fee=0; no result is ever issued.
